delay_write_sched: RTL and testbench

DELAY_WRITE_SCHED -- requirements
Module: delay_write_sched

---
 rtl/dws_pkg.sv | 24 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/delay_write_sched.sv | 186 ++++++++++++++++++
 tb/tb_delay_write_sched.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dws_pkg.sv
// Shared defaults, target-select encodings and sequence-stamp helper for delay_write_sched.
package dws_pkg;

    localparam int DW_DEF    = 3;
    localparam int DLYW_DEF  = 5;
    localparam int DEPTH_DEF = 4;
    localparam int SEQW      = 3;

    localparam logic SEL_A1 = 1'b0;
    localparam logic SEL_A2 = 1'b1;

    typedef enum logic {
        PRIO_REQ0 = 1'b0,
        PRIO_REQ1 = 1'b1
    } prio_e;

    typedef logic [SEQW-1:0] seq_t;

    // Number of issues since this stamp was handed out: smaller is newer.
    function automatic seq_t seq_age(input seq_t next_seq, input seq_t stamp);
        return seq_t'(next_seq - stamp - 3'd1);
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: one-hot grant, priority flips to the other
// requester whenever a grant is accepted.
module rr_arb2
    import dws_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] i_req,
    input  logic       i_accept,
    output logic [1:0] o_grant
);

    prio_e r_prio;

    // Grant selection: a lone requester wins, contention goes to the favoured one.
    always_comb begin
        o_grant = 2'b00;
        case (i_req)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (r_prio == PRIO_REQ0) ? 2'b01 : 2'b10;
            default: o_grant = 2'b00;
        endcase
    end

    // Priority register: favour the requester that was not just served.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= PRIO_REQ0;
        end else if (i_accept) begin
            r_prio <= o_grant[0] ? PRIO_REQ1 : PRIO_REQ0;
        end else begin
            r_prio <= r_prio;
        end
    end

endmodule

// File: rtl/delay_write_sched.sv
// Delayed-write scheduler: two requesters post writes to a1/a2 that commit after a
// per-request delay. Optional collision counter enabled by DWS_COLLIDE_CNT_EN.
module delay_write_sched
    import dws_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DLYW  = DLYW_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic            req0_sel,
    input  logic [DW-1:0]   req0_data,
    input  logic [DLYW-1:0] req0_dly,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic            req1_sel,
    input  logic [DW-1:0]   req1_data,
    input  logic [DLYW-1:0] req1_dly,
    output logic [DW-1:0]   a1,
    output logic [DW-1:0]   a2,
    output logic            full,
    output logic            busy
`ifdef DWS_COLLIDE_CNT_EN
    ,
    output logic [7:0]      collide_cnt
`endif
);

    localparam int SLOTW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0] r_vld;
    logic [DEPTH-1:0] r_sel;
    logic [DLYW-1:0]  r_cnt  [DEPTH];
    logic [DW-1:0]    r_data [DEPTH];
    seq_t             r_seq  [DEPTH];
    seq_t             r_seq_ctr;
    logic [DW-1:0]    r_a1;
    logic [DW-1:0]    r_a2;

    logic [DEPTH-1:0]      w_commit;
    logic [DEPTH-1:0]      w_free;
    logic                  w_full;
    logic [1:0]            w_grant;
    logic                  w_accept;
    logic                  w_in_sel;
    logic [DW-1:0]         w_in_data;
    logic [DLYW-1:0]       w_in_dly;
    logic [SLOTW-1:0]      w_slot;
    logic [1:0]            w_wr_en;
    logic [1:0][DW-1:0]    w_wr_data;
    logic [1:0][SEQW-1:0]  w_best_age;
`ifdef DWS_COLLIDE_CNT_EN
    logic                  w_discard;
    logic [7:0]            r_collide_cnt;
`endif

    // Entries whose countdown has reached zero commit at the next edge, so their
    // slot counts as free for a request accepted on that same edge.
    always_comb begin
        w_commit = {DEPTH{1'b0}};
        w_free   = {DEPTH{1'b0}};
        for (int i = 0; i < DEPTH; i++) begin
            w_commit[i] = r_vld[i] && (r_cnt[i] == {DLYW{1'b0}});
            w_free[i]   = !r_vld[i] || w_commit[i];
        end
    end

    assign w_full = &(~w_free);
    assign full   = w_full;
    assign busy   = |r_vld;

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_req    ({req1_valid, req0_valid}),
        .i_accept (w_accept),
        .o_grant  (w_grant)
    );

    assign req0_ready = rst_n && w_grant[0] && !w_full;
    assign req1_ready = rst_n && w_grant[1] && !w_full;
    assign w_accept   = (req0_valid && req0_ready) || (req1_valid && req1_ready);

    assign w_in_sel  = w_grant[1] ? req1_sel  : req0_sel;
    assign w_in_data = w_grant[1] ? req1_data : req0_data;
    assign w_in_dly  = w_grant[1] ? req1_dly  : req0_dly;

    // Lowest-index free slot: scan downwards so the smallest index is written last.
    always_comb begin
        w_slot = {SLOTW{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            w_slot = w_free[i] ? SLOTW'(i) : w_slot;
        end
    end

    // Per-target commit resolution: the newest stamp among same-cycle commits wins.
    always_comb begin
        w_wr_en    = 2'b00;
        w_wr_data  = {2{{DW{1'b0}}}};
        w_best_age = {2{{SEQW{1'b0}}}};
`ifdef DWS_COLLIDE_CNT_EN
        w_discard  = 1'b0;
`endif
        for (int i = 0; i < DEPTH; i++) begin
            logic w_tgt;
            logic w_take;
            seq_t w_age;
            w_tgt  = r_sel[i];
            w_age  = seq_age(r_seq_ctr, r_seq[i]);
            w_take = w_commit[i] && (!w_wr_en[w_tgt] || (w_age < w_best_age[w_tgt]));
`ifdef DWS_COLLIDE_CNT_EN
            w_discard = w_discard || (w_commit[i] && w_wr_en[w_tgt]);
`endif
            w_wr_data[w_tgt]  = w_take ? r_data[i] : w_wr_data[w_tgt];
            w_best_age[w_tgt] = w_take ? w_age : w_best_age[w_tgt];
            w_wr_en[w_tgt]    = w_wr_en[w_tgt] || w_take;
        end
    end

    // Entry table: count down, retire on commit, load an accepted request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld     <= {DEPTH{1'b0}};
            r_sel     <= {DEPTH{1'b0}};
            r_seq_ctr <= {SEQW{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                r_cnt[i]  <= {DLYW{1'b0}};
                r_data[i] <= {DW{1'b0}};
                r_seq[i]  <= {SEQW{1'b0}};
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_commit[i]) begin
                    r_vld[i] <= 1'b0;
                end else if (r_vld[i]) begin
                    r_cnt[i] <= r_cnt[i] - {{(DLYW-1){1'b0}}, 1'b1};
                end else begin
                    r_vld[i] <= 1'b0;
                end
            end
            if (w_accept) begin
                r_vld[w_slot]  <= 1'b1;
                r_sel[w_slot]  <= w_in_sel;
                r_cnt[w_slot]  <= w_in_dly;
                r_data[w_slot] <= w_in_data;
                r_seq[w_slot]  <= r_seq_ctr;
                r_seq_ctr      <= r_seq_ctr + 3'd1;
            end else begin
                r_seq_ctr      <= r_seq_ctr;
            end
        end
    end

    // Target registers: hold unless a commit resolves to them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a1 <= {DW{1'b0}};
            r_a2 <= {DW{1'b0}};
        end else begin
            r_a1 <= w_wr_en[SEL_A1] ? w_wr_data[SEL_A1] : r_a1;
            r_a2 <= w_wr_en[SEL_A2] ? w_wr_data[SEL_A2] : r_a2;
        end
    end

    assign a1 = r_a1;
    assign a2 = r_a2;

`ifdef DWS_COLLIDE_CNT_EN
    // Saturating count of cycles that dropped at least one write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_collide_cnt <= 8'd0;
        end else if (w_discard && (r_collide_cnt != 8'hFF)) begin
            r_collide_cnt <= r_collide_cnt + 8'd1;
        end else begin
            r_collide_cnt <= r_collide_cnt;
        end
    end

    assign collide_cnt = r_collide_cnt;
`endif

endmodule

// File: tb/tb_delay_write_sched.sv
// Scoreboard bench for delay_write_sched: a queue-based reference model predicts each
// cycle's outputs; a negedge monitor pops and compares. Honours DWS_COLLIDE_CNT_EN.
module tb_delay_write_sched;

    localparam int DW    = 3;
    localparam int DLYW  = 5;
    localparam int DEPTH = 4;

    logic            clk   = 1'b1;
    logic            rst_n = 1'b0;
    logic            req0_valid = 1'b0, req0_sel = 1'b0, req0_ready;
    logic            req1_valid = 1'b0, req1_sel = 1'b0, req1_ready;
    logic [DW-1:0]   req0_data = 3'd0, req1_data = 3'd0;
    logic [DLYW-1:0] req0_dly = 5'd0, req1_dly = 5'd0;
    logic [DW-1:0]   a1, a2;
    logic            full, busy;
`ifdef DWS_COLLIDE_CNT_EN
    logic [7:0]      collide_cnt;
`endif

    delay_write_sched #(.DW(DW), .DLYW(DLYW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel),
        .req0_data(req0_data), .req0_dly(req0_dly),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel),
        .req1_data(req1_data), .req1_dly(req1_dly),
        .a1(a1), .a2(a2), .full(full), .busy(busy)
`ifdef DWS_COLLIDE_CNT_EN
        , .collide_cnt(collide_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct { int cedge; bit sel; logic [2:0] data; int order; } pend_t;
    typedef struct { logic [2:0] a1; logic [2:0] a2; bit full; bit busy; bit r0; bit r1; } exp_t;

    exp_t  exp_q[$];
    pend_t pend[$];
    int    checks = 0;
    int    errors = 0;
    int    edge_n = 0;
    int    m_order = 0;
    int    m_coll = 0;
    bit    m_pref = 1'b0;
    logic [2:0] m_a1 = 3'd0, m_a2 = 3'd0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, req);
        end
    endtask

    // Monitor: one expectation per cycle, compared away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                exp_t e;
                e = exp_q.pop_front();
                check("mon_a1", a1, e.a1);
                check("mon_a2", a2, e.a2);
                check("mon_full", full, e.full);
                check("mon_busy", busy, e.busy);
                check("mon_ready0", req0_ready, e.r0);
                check("mon_ready1", req1_ready, e.r1);
            end
        end
    end

    // Drive one cycle, predict its outputs, advance the model over the next edge.
    task automatic drive_cycle(input bit v0, input bit s0, input logic [2:0] d0, input logic [4:0] l0,
                               input bit v1, input bit s1, input logic [2:0] d1, input logic [4:0] l1,
                               output bit g0, output bit g1);
        int    ncomm;
        bit    mfull, disc;
        exp_t  e;
        pend_t keep[$];
        req0_valid = v0; req0_sel = s0; req0_data = d0; req0_dly = l0;
        req1_valid = v1; req1_sel = s1; req1_data = d1; req1_dly = l1;
        ncomm = 0;
        foreach (pend[j]) if (pend[j].cedge == edge_n + 1) ncomm++;
        mfull = ((pend.size() - ncomm) == DEPTH);
        g0 = 1'b0; g1 = 1'b0;
        if (!mfull) begin
            if (v0 && v1) begin
                g0 = !m_pref; g1 = m_pref;
            end else begin
                g0 = v0; g1 = v1;
            end
        end
        e.a1 = m_a1; e.a2 = m_a2; e.full = mfull; e.busy = (pend.size() != 0);
        e.r0 = g0; e.r1 = g1;
        exp_q.push_back(e);
        disc = 1'b0;
        for (int t = 0; t < 2; t++) begin
            int n, best, bo;
            n = 0; best = -1; bo = -1;
            foreach (pend[j]) begin
                if (pend[j].cedge == edge_n + 1 && pend[j].sel == t[0]) begin
                    n++;
                    if (pend[j].order > bo) begin bo = pend[j].order; best = j; end
                end
            end
            if (n > 0 && t == 0) m_a1 = pend[best].data;
            if (n > 0 && t == 1) m_a2 = pend[best].data;
            if (n > 1) disc = 1'b1;
        end
        if (disc && m_coll < 255) m_coll++;
        foreach (pend[j]) if (pend[j].cedge != edge_n + 1) keep.push_back(pend[j]);
        pend = keep;
        if (g0) begin
            pend.push_back('{edge_n + 2 + int'(l0), s0, d0, m_order});
            m_order++; m_pref = 1'b1;
        end else if (g1) begin
            pend.push_back('{edge_n + 2 + int'(l1), s1, d1, m_order});
            m_order++; m_pref = 1'b0;
        end
        edge_n++;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        bit g0, g1;
        for (int i = 0; i < n; i++) drive_cycle(0, 0, 3'd0, 5'd0, 0, 0, 3'd0, 5'd0, g0, g1);
    endtask

    // Reset for one cycle; outputs must clear without waiting for an edge.
    task automatic do_reset();
        exp_t e;
        rst_n = 1'b0;
        pend.delete();
        m_a1 = 3'd0; m_a2 = 3'd0; m_pref = 1'b0; m_coll = 0;
        e = '{3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
        exp_q.push_back(e);
        #1;
        check("rst_async_a1", a1, 3'd0);
        check("rst_async_a2", a2, 3'd0);
        check("rst_async_busy", busy, 1'b0);
        check("rst_async_ready0", req0_ready, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit g0, g1;
        bit p0, p1, s0, s1;
        logic [2:0] d0, d1;
        logic [4:0] l0, l1;

        do_reset();
        idle(2);

        // Long delay to a2.
        drive_cycle(1, 1, 3'b010, 5'd20, 0, 0, 3'd0, 5'd0, g0, g1);
        idle(20);
        check("dly20_a2_before", a2, 3'd0);
        idle(1);
        check("dly20_a2_after", a2, 3'b010);
        check("dly20_a1", a1, 3'd0);

        // Contention from reset: req0 first, then req1.
        do_reset();
        req0_valid = 1'b1; req0_sel = 1'b0; req0_data = 3'd1; req0_dly = 5'd0;
        req1_valid = 1'b1; req1_sel = 1'b1; req1_data = 3'd6; req1_dly = 5'd0;
        #1;
        check("arb_first_r0", req0_ready, 1'b1);
        check("arb_first_r1", req1_ready, 1'b0);
        drive_cycle(1, 0, 3'd1, 5'd0, 1, 1, 3'd6, 5'd0, g0, g1);
        req0_data = 3'd5;
        #1;
        check("arb_second_r0", req0_ready, 1'b0);
        check("arb_second_r1", req1_ready, 1'b1);
        drive_cycle(1, 0, 3'd5, 5'd0, 1, 1, 3'd6, 5'd0, g0, g1);
        idle(3);

        // Fill all entries, then a fifth waits for the first commit cycle.
        do_reset();
        for (int k = 0; k < 4; k++) drive_cycle(1, 0, 3'(k + 1), 5'd31, 0, 0, 3'd0, 5'd0, g0, g1);
        check("fill_full", full, 1'b1);
        for (int k = 0; k < 28; k++) begin
            req1_valid = 1'b1; req1_sel = 1'b1; req1_data = 3'd7; req1_dly = 5'd0;
            #1;
            if (k == 0) check("fill_fifth_blocked", req1_ready, 1'b0);
            drive_cycle(0, 0, 3'd0, 5'd0, 1, 1, 3'd7, 5'd0, g0, g1);
        end
        req1_valid = 1'b1;
        #1;
        check("fill_commit_full", full, 1'b0);
        check("fill_commit_ready", req1_ready, 1'b1);
        drive_cycle(0, 0, 3'd0, 5'd0, 1, 1, 3'd7, 5'd0, g0, g1);
        idle(6);

        // Same-cycle collision on a1: last issued wins.
        do_reset();
        drive_cycle(1, 0, 3'd1, 5'd5, 0, 0, 3'd0, 5'd0, g0, g1);
        drive_cycle(1, 0, 3'd3, 5'd4, 0, 0, 3'd0, 5'd0, g0, g1);
        idle(4);
        check("collide_a1_before", a1, 3'd0);
        idle(1);
        check("collide_a1_after", a1, 3'd3);
`ifdef DWS_COLLIDE_CNT_EN
        check("collide_cnt_one", collide_cnt, 8'd1);
`endif

        // Reset with pending entries discards them.
        do_reset();
        drive_cycle(1, 0, 3'd5, 5'd0, 0, 0, 3'd0, 5'd0, g0, g1);
        drive_cycle(1, 1, 3'd6, 5'd10, 0, 0, 3'd0, 5'd0, g0, g1);
        drive_cycle(1, 0, 3'd2, 5'd10, 0, 0, 3'd0, 5'd0, g0, g1);
        drive_cycle(1, 1, 3'd4, 5'd10, 0, 0, 3'd0, 5'd0, g0, g1);
        check("midrst_a1_set", a1, 3'd5);
        check("midrst_busy", busy, 1'b1);
        do_reset();
        idle(15);
        check("midrst_a1_after", a1, 3'd0);
        check("midrst_a2_after", a2, 3'd0);

        // Randomised traffic with short delays.
        do_reset();
        p0 = 1'b0; p1 = 1'b0;
        s0 = 1'b0; s1 = 1'b0; d0 = 3'd0; d1 = 3'd0; l0 = 5'd0; l1 = 5'd0;
        for (int k = 0; k < 400; k++) begin
            if (!p0 && $urandom_range(0, 3) != 0) begin
                p0 = 1'b1; s0 = 1'($urandom_range(0, 1));
                d0 = 3'($urandom_range(0, 7)); l0 = 5'($urandom_range(0, 7));
            end
            if (!p1 && $urandom_range(0, 3) != 0) begin
                p1 = 1'b1; s1 = 1'($urandom_range(0, 1));
                d1 = 3'($urandom_range(0, 7)); l1 = 5'($urandom_range(0, 7));
            end
            drive_cycle(p0, s0, d0, l0, p1, s1, d1, l1, g0, g1);
            if (g0) p0 = 1'b0;
            if (g1) p1 = 1'b0;
        end
        idle(10);
`ifdef DWS_COLLIDE_CNT_EN
        check("collide_cnt_final", collide_cnt, 32'(m_coll));
`endif
        @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
